// File: rtl/dat_fill_seq.sv
// DAT background sequencer: fills one task's entries with a constant or incrementing
// pattern, or copies one task to another, using DAT cycles the CPU leaves idle.
module dat_fill_seq #(
  parameter int unsigned TASK_W = 12,
  parameter int unsigned IDX_W  = 3,
  parameter int unsigned DATA_W = 16
) (
  input  logic                    e,
  input  logic                    _reset,
  input  logic                    start,
  input  logic [1:0]              mode,
  input  logic [TASK_W-1:0]       src_task,
  input  logic [TASK_W-1:0]       dst_task,
  input  logic [DATA_W-1:0]       fill_base,
  input  logic                    abort,
  input  logic                    cpu_dat_busy,
  output logic                    seq_grant,
  output logic [TASK_W+IDX_W-1:0] seq_addr,
  output logic [DATA_W-1:0]       seq_wdata,
  output logic                    seq_we,
  input  logic [DATA_W-1:0]       seq_rdata,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  typedef enum logic [1:0] {StIdle, StRd, StWr} state_e;

  state_e                    state_q;
  logic [IDX_W-1:0]          idx_q;
  logic [DATA_W-1:0]         hold_q;
  logic [1:0]                mode_q;
  logic [TASK_W-1:0]         src_q;
  logic [TASK_W-1:0]         dst_q;
  logic [DATA_W-1:0]         base_q;
  logic [TASK_W+IDX_W-1:0]   addr_q;
  logic [DATA_W-1:0]         wdata_q;
  logic                      done_q;
  logic                      err_q;

  logic                      active;
  logic [TASK_W+IDX_W-1:0]   cur_addr;
  logic [DATA_W-1:0]         wr_data;

  always_comb begin
    active   = (state_q != StIdle);
    cur_addr = (state_q == StRd) ? {src_q, idx_q} : {dst_q, idx_q};
    case (mode_q)
      2'b00:   wr_data = base_q;
      2'b01:   wr_data = base_q + DATA_W'(idx_q);
      default: wr_data = hold_q;
    endcase
  end

  // CPU always wins the DAT port; abort suppresses the write of its own cycle.
  assign seq_grant = active & ~cpu_dat_busy;
  assign seq_we    = (state_q == StWr) & seq_grant & ~abort;
  assign seq_addr  = active ? cur_addr : addr_q;
  assign seq_wdata = (state_q == StWr) ? wr_data : wdata_q;
  assign busy      = active;
  assign done      = done_q;
  assign err       = err_q;

  always_ff @(posedge e or negedge _reset) begin
    if (!_reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      hold_q  <= '0;
      mode_q  <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      base_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      // Keep the last driven address/data visible once the sequencer goes idle.
      if (active) addr_q <= cur_addr;
      if (state_q == StWr) wdata_q <= wr_data;
      case (state_q)
        StIdle: begin
          if (start) begin
            if (mode == 2'b11) begin
              err_q <= 1'b1;
            end else begin
              mode_q  <= mode;
              src_q   <= src_task;
              dst_q   <= dst_task;
              base_q  <= fill_base;
              idx_q   <= '0;
              state_q <= (mode == 2'b10) ? StRd : StWr;
            end
          end
        end
        StRd: begin
          if (abort) begin
            state_q <= StIdle;
            err_q   <= 1'b1;
          end else if (seq_grant) begin
            hold_q  <= seq_rdata;
            state_q <= StWr;
          end
        end
        StWr: begin
          if (abort) begin
            state_q <= StIdle;
            err_q   <= 1'b1;
          end else if (seq_grant) begin
            if (idx_q == '1) begin
              state_q <= StIdle;
              done_q  <= 1'b1;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= (mode_q == 2'b10) ? StRd : StWr;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dat_fill_seq.sv
// Scoreboard bench for dat_fill_seq: a task-level model predicts every DAT write and
// completion pulse; a negedge monitor compares them against the DUT.
module tb_dat_fill_seq;

  logic        e = 1'b0;
  logic        _reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mode = '0;
  logic [11:0] src_task = '0;
  logic [11:0] dst_task = '0;
  logic [15:0] fill_base = '0;
  logic        abort = 1'b0;
  logic        cpu_dat_busy = 1'b0;
  logic        seq_grant;
  logic [14:0] seq_addr;
  logic [15:0] seq_wdata;
  logic        seq_we;
  logic [15:0] seq_rdata;
  logic        busy;
  logic        done;
  logic        err;

  dat_fill_seq #(.TASK_W(12), .IDX_W(3), .DATA_W(16)) dut (
    .e            (e),
    ._reset       (_reset),
    .start        (start),
    .mode         (mode),
    .src_task     (src_task),
    .dst_task     (dst_task),
    .fill_base    (fill_base),
    .abort        (abort),
    .cpu_dat_busy (cpu_dat_busy),
    .seq_grant    (seq_grant),
    .seq_addr     (seq_addr),
    .seq_wdata    (seq_wdata),
    .seq_we       (seq_we),
    .seq_rdata    (seq_rdata),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 e = ~e;

  // DAT SRAM: asynchronous read, synchronous write.
  logic [15:0] mem [0:32767];
  logic [15:0] ref_mem [0:32767];
  bit          mem_init;
  assign seq_rdata = mem[seq_addr];

  always @(posedge e) begin
    if (!mem_init) begin
      for (int i = 0; i < 32768; i++) mem[i] <= 16'h0;
      mem_init <= 1'b1;
    end else if (seq_grant && seq_we) begin
      mem[seq_addr] <= seq_wdata;
    end
  end

  int          checks = 0;
  int          errors = 0;
  bit          sb_off = 1'b0;
  logic [30:0] wq [$];
  bit          eq [$];
  logic [30:0] wexp;
  logic [1:0]  cexp;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every DAT write and every done/err pulse must match the next expectation.
  always @(negedge e) begin
    if (_reset && !sb_off) begin
      if (seq_we) begin
        chk("we_only_when_granted", {62'b0, seq_grant, cpu_dat_busy}, 64'b10);
        if (wq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected none", seq_addr,
                   seq_wdata);
        end else begin
          wexp = wq.pop_front();
          chk("write_addr", seq_addr, wexp[30:16]);
          chk("write_data", seq_wdata, wexp[15:0]);
        end
      end
      if (done || err) begin
        if (eq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_completion: got done %0b err %0b expected none", done, err);
        end else begin
          cexp = eq.pop_front() ? 2'b10 : 2'b01;
          chk("completion_done_err", {done, err}, cexp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge e);
    #1;
  endtask

  // Reference model: the 8 values a command writes, from the command's own rules.
  task automatic push_cmd(input logic [1:0] m, input logic [11:0] s, input logic [11:0] d,
                          input logic [15:0] b, input int nwr);
    logic [15:0] v [8];
    for (int i = 0; i < 8; i++) begin
      if (m == 2'b00)      v[i] = b;
      else if (m == 2'b01) v[i] = 16'(b + 16'(i));
      else                 v[i] = ref_mem[{s, 3'(i)}];
    end
    for (int i = 0; i < nwr; i++) begin
      wq.push_back({d, 3'(i), v[i]});
      ref_mem[{d, 3'(i)}] = v[i];
    end
  endtask

  task automatic start_cmd(input logic [1:0] m, input logic [11:0] s, input logic [11:0] d,
                           input logic [15:0] b);
    mode = m;
    src_task = s;
    dst_task = d;
    fill_base = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // pat: 0 CPU idle, 1 CPU busy on odd cycles, 2 random CPU traffic.
  task automatic wait_end(input int n0, input int pat, output int n);
    n = n0;
    while (!(done || err) && n < 200) begin
      if (pat == 1)      cpu_dat_busy = n[0];
      else if (pat == 2) cpu_dat_busy = ($urandom % 4) == 0;
      else               cpu_dat_busy = 1'b0;
      tick();
      n++;
    end
    cpu_dat_busy = 1'b0;
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL completion_timeout: got no done/err after %0d cycles expected one", n);
    end
  endtask

  task automatic run(input logic [1:0] m, input logic [11:0] s, input logic [11:0] d,
                     input logic [15:0] b, input int pat, input int exp_cyc, input string nm);
    int n;
    push_cmd(m, s, d, b, 8);
    eq.push_back(1'b1);
    start_cmd(m, s, d, b);
    wait_end(1, pat, n);
    if (exp_cyc > 0) chk(nm, n, exp_cyc);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no summary expected end of test");
    $fatal(1);
  end

  initial begin
    int n;
    logic [11:0] tl [11];
    for (int i = 0; i < 32768; i++) ref_mem[i] = 16'h0;

    repeat (3) tick();
    chk("reset_outputs", {busy, seq_grant, seq_we, done, err, seq_addr, seq_wdata}, 64'h0);
    _reset = 1'b1;
    tick();

    run(2'b01, 12'h000, 12'h005, 16'h0040, 0, 9, "fill_inc_latency");
    run(2'b00, 12'h000, 12'hFFF, 16'h003F, 0, 9, "fill_const_latency");
    run(2'b01, 12'h000, 12'h003, 16'hFFFE, 0, 9, "fill_inc_wrap_latency");
    run(2'b01, 12'h000, 12'h001, 16'h0100, 0, 9, "preload_latency");

    // Copy task 1 -> task 2 with read/write address phases checked.
    push_cmd(2'b10, 12'h001, 12'h002, 16'h0, 8);
    eq.push_back(1'b1);
    start_cmd(2'b10, 12'h001, 12'h002, 16'h0);
    chk("copy_rd_phase", {seq_grant, seq_we, 1'b0, seq_addr}, {2'b10, 1'b0, 15'h008});
    tick();
    chk("copy_wr_phase", {seq_grant, seq_we, 1'b0, seq_addr}, {2'b11, 1'b0, 15'h010});
    wait_end(2, 0, n);
    chk("copy_latency", n, 17);

    run(2'b00, 12'h000, 12'h006, 16'h1234, 1, 17, "contended_fill_latency");

    // Abort after the third write: entries 3..7 of task 0x0AB stay untouched.
    push_cmd(2'b01, 12'h000, 12'h0AB, 16'h5000, 3);
    eq.push_back(1'b0);
    start_cmd(2'b01, 12'h000, 12'h0AB, 16'h5000);
    tick();
    tick();
    tick();
    abort = 1'b1;
    #1;
    chk("abort_blocks_write", seq_we, 1'b0);
    tick();
    abort = 1'b0;
    chk("abort_err_pulse", {busy, done, err}, 3'b001);
    tick();

    eq.push_back(1'b0);
    start_cmd(2'b11, 12'h000, 12'h007, 16'h9999);
    chk("illegal_mode_err", {busy, seq_grant, err}, 3'b001);
    tick();
    chk("illegal_mode_pulse_len", {busy, err}, 2'b00);

    // Reset in the middle of a copy into a scratch task.
    sb_off = 1'b1;
    start_cmd(2'b10, 12'h002, 12'h100, 16'h0);
    repeat (4) tick();
    _reset = 1'b0;
    #1;
    chk("reset_mid_copy_outputs", {busy, seq_grant, seq_we, done, err, seq_addr, seq_wdata},
        64'h0);
    tick();
    _reset = 1'b1;
    sb_off = 1'b0;
    tick();
    push_cmd(2'b01, 12'h000, 12'h101, 16'h0077, 8);
    eq.push_back(1'b1);
    start_cmd(2'b01, 12'h000, 12'h101, 16'h0077);
    chk("after_reset_first_addr", seq_addr, {12'h101, 3'd0});
    wait_end(1, 0, n);
    chk("after_reset_latency", n, 9);

    // Random back-to-back commands among tasks 0..7 under random CPU traffic.
    for (int k = 0; k < 40; k++) begin
      run(2'($urandom % 3), 12'($urandom % 8), 12'($urandom % 8), 16'($urandom), 2, 0, "");
    end
    repeat (2) tick();

    chk("writes_all_seen", wq.size(), 0);
    chk("completions_all_seen", eq.size(), 0);
    for (int t = 0; t < 8; t++) tl[t] = 12'(t);
    tl[8] = 12'hFFF;
    tl[9] = 12'h0AB;
    tl[10] = 12'h101;
    for (int t = 0; t < 11; t++) begin
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("dat_%03h_%0d", tl[t], i), mem[{tl[t], 3'(i)}], ref_mem[{tl[t], 3'(i)}]);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
